// File: rtl/alu_mul_sequencer_pkg.sv
// Shared LEGv8 EX-stage constants: opcodes, ALUCnt encodings and the
// multiply sequencer state type.
package alu_mul_sequencer_pkg;

    // R-type opcodes seen in the EX stage.
    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_MUL = 11'b10011011000;

    // ALUCnt encodings understood by the shared ALU.
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shares the EX-stage ALU between pass-through pipeline traffic and an
// iterative shift-add multiply. While a MUL runs, the block owns the ALU,
// stalls the pipeline and feeds one add per cycle; the truncated product is
// strobed for a single cycle before the ALU is handed back.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int          WIDTH      = 64,
    parameter logic [10:0] MUL_OPCODE = OP_MUL,
    parameter logic [3:0]  CNT_ADD    = ALU_ADD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [10:0]      ex_opcode,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    input  logic [3:0]       ex_alucnt,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_cnt,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mul_state_t     state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    count_reg;

    logic mul_hit;
    logic last_step;

    assign mul_hit = ex_valid & (ex_opcode == MUL_OPCODE) & ~flush;

    // Stop as soon as no multiplier bits remain, so short multipliers finish
    // early; the step counter bounds the worst case at WIDTH add steps.
    assign last_step = ((mplier_reg >> 1) == '0) || (count_reg == LAST_STEP);

    // Sequencer FSM and shift/accumulate datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mul_hit) begin
                        mcand_reg  <= ex_a;
                        mplier_reg <= ex_b;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        state_reg  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        // Partial product is abandoned; nothing is loaded.
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg    <= alu_result;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        count_reg  <= count_reg + 1'b1;
                        if (last_step) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // The opcode is deliberately ignored here: the MUL that just
                    // finished is still in ID/EX and must not retrigger.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU operand steering, stall generation and product strobe.
    always_comb begin
        alu_a        = ex_a;
        alu_b        = ex_b;
        alu_cnt      = ex_alucnt;
        stall        = 1'b0;
        result_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                stall = mul_hit;
            end
            ST_RUN: begin
                alu_a   = acc_reg;
                alu_b   = mplier_reg[0] ? mcand_reg : '0;
                alu_cnt = CNT_ADD;
                stall   = ~flush;
            end
            ST_DONE: begin
                result_valid = ~flush;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        if (reset) begin
            stall        = 1'b0;
            result_valid = 1'b0;
        end
    end

    assign busy   = (state_reg == ST_RUN);
    assign result = acc_reg;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: a behavioural ALU closes the loop,
// MUL transactions push their expected product and stall length to a
// scoreboard queue, and each result strobe pops and compares.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         ex_valid;
    logic [10:0]  ex_opcode;
    logic [W-1:0] ex_a;
    logic [W-1:0] ex_b;
    logic [3:0]   ex_alucnt;
    logic [W-1:0] alu_result;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_cnt;
    logic         stall;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        int           stalls;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(
        .WIDTH      (W),
        .MUL_OPCODE (OP_MUL),
        .CNT_ADD    (ALU_ADD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_alucnt    (ex_alucnt),
        .alu_result   (alu_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cnt      (alu_cnt),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    // Behavioural model of the shared EX-stage ALU.
    always_comb begin
        case (alu_cnt)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [10:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] cnt);
        ex_valid  = v;
        ex_opcode = op;
        ex_a      = a;
        ex_b      = b;
        ex_alucnt = cnt;
    endtask

    // Stall length of a MUL: detect cycle plus one RUN cycle per multiplier
    // bit up to and including the highest set bit.
    function automatic int model_stalls(input logic [W-1:0] b);
        int k;
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) k = i;
        end
        return k + 2;
    endfunction

    // Present one MUL, follow it through the stall, compare the strobe
    // against the scoreboard and retire it so the next slot is a bubble.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        exp_t got;
        int   n;
        e.res    = a * b;
        e.stalls = model_stalls(b);
        sb.push_back(e);
        @(negedge clk);
        drive(1'b1, OP_MUL, a, b, ALU_AND);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!stall) break;
            n++;
            if (busy) check("run_alucnt", {60'd0, alu_cnt}, {60'd0, ALU_ADD});
            @(negedge clk);
        end
        got = sb.pop_front();
        check("stall_cycles", W'(n), W'(got.stalls));
        check("result_valid", {63'd0, result_valid}, 64'd1);
        check("result", result, got.res);
        $display("MUL a=%h b=%h stalls=%0d result=%h expected=%h", a, b, n, result, got.res);
        @(negedge clk);
        drive(1'b0, OP_ADD, '0, '0, ALU_ADD);
        #1;
        check("post_strobe_rv", {63'd0, result_valid}, 64'd0);
        check("post_strobe_stall", {63'd0, stall}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, OP_MUL, 64'd5, 64'd3, ALU_ADD);

        // Reset held with a MUL presented: stall must stay low.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("stall_in_reset", {63'd0, stall}, 64'd0);

        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, OP_ADD, 64'd7, 64'd9, ALU_ADD);
        #1;
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rv", {63'd0, result_valid}, 64'd0);
        check("rst_result", result, 64'd0);

        // ADD passes straight through for several cycles.
        for (int i = 0; i < 3; i++) begin
            check("add_alu_a", alu_a, 64'd7);
            check("add_alu_b", alu_b, 64'd9);
            check("add_alu_cnt", {60'd0, alu_cnt}, {60'd0, ALU_ADD});
            check("add_stall", {63'd0, stall}, 64'd0);
            check("add_rv", {63'd0, result_valid}, 64'd0);
            @(negedge clk);
            #1;
        end
        $display("ADD a=7 b=9 alu_a=%0d alu_b=%0d alu_cnt=%b", alu_a, alu_b, alu_cnt);

        run_mul(64'd3, 64'd5);
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_mul(64'd12345, 64'd0);
        run_mul(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);

        // Flush in the third RUN cycle of a long MUL.
        @(negedge clk);
        drive(1'b1, OP_MUL, 64'd3, 64'hFF, ALU_ADD);
        #1;
        check("flush_detect_stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_cycle_stall", {63'd0, stall}, 64'd0);
        check("flush_cycle_rv", {63'd0, result_valid}, 64'd0);
        check("flush_cycle_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, OP_ADD, '0, '0, ALU_ADD);
        #1;
        check("flush_after_busy", {63'd0, busy}, 64'd0);
        check("flush_after_stall", {63'd0, stall}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("flush_no_rv", {63'd0, result_valid}, 64'd0);
            @(negedge clk);
            #1;
        end
        drive(1'b1, OP_SUB, 64'd100, 64'd30, ALU_SUB);
        #1;
        check("sub_alu_a", alu_a, 64'd100);
        check("sub_alu_b", alu_b, 64'd30);
        check("sub_alu_cnt", {60'd0, alu_cnt}, {60'd0, ALU_SUB});
        check("sub_stall", {63'd0, stall}, 64'd0);
        $display("FLUSHED MUL a=3 b=ff then SUB alu_a=%0d alu_b=%0d alu_cnt=%b", alu_a, alu_b, alu_cnt);

        // Reset pulse in the middle of a MUL, then the MUL again.
        @(negedge clk);
        drive(1'b1, OP_MUL, 64'd6, 64'd7, ALU_ADD);
        @(negedge clk);
        #1;
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, OP_ADD, 64'd1, 64'd2, ALU_ADD);
        #1;
        check("after_reset_busy", {63'd0, busy}, 64'd0);
        check("after_reset_rv", {63'd0, result_valid}, 64'd0);
        check("after_reset_result", result, 64'd0);
        check("after_reset_alu_a", alu_a, 64'd1);
        $display("RESET mid-MUL a=6 b=7 busy=%0d result=%h", busy, result);
        run_mul(64'd6, 64'd7);

        check("scoreboard_empty", W'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
